// File: rtl/cobalt_pkg.sv
// Shared integer-pipeline definitions: ALU opcodes, default widths and the
// issue-queue entry layout.
package cobalt_pkg;

    localparam int unsigned OpW      = 4;
    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefTagW  = 6;

    localparam logic [OpW-1:0] OpAdd  = 4'b0000;
    localparam logic [OpW-1:0] OpAddu = 4'b0001;
    localparam logic [OpW-1:0] OpSub  = 4'b0010;
    localparam logic [OpW-1:0] OpSubu = 4'b0011;
    localparam logic [OpW-1:0] OpAnd  = 4'b0100;
    localparam logic [OpW-1:0] OpOr   = 4'b0101;
    localparam logic [OpW-1:0] OpNor  = 4'b0111;
    localparam logic [OpW-1:0] OpSlt  = 4'b1010;
    localparam logic [OpW-1:0] OpSltu = 4'b1011;

    typedef struct packed {
        logic                valid;
        logic [OpW-1:0]      opcode;
        logic [DefDataW-1:0] rs_data;
        logic                rs_valid;
        logic [DefTagW-1:0]  rs_tag;
        logic [DefDataW-1:0] rt_data;
        logic                rt_valid;
        logic [DefTagW-1:0]  rt_tag;
        logic [DefTagW-1:0]  rd_tag;
    } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// Oldest-ready picker: grants the lowest-index set bit of the ready vector.
module iq_select
    import cobalt_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant,
    output logic             any_ready
);

    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any_ready = |ready;

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue: compacting, age-ordered reservation station that snoops
// the CDB for missing operands and issues the oldest ready op to the ALU.
module int_issue_queue
    import cobalt_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned TAG_W  = DefTagW,
    parameter int unsigned OP_W   = OpW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              disp_valid,
    input  logic [OP_W-1:0]   disp_opcode,
    input  logic [DATA_W-1:0] disp_rsdata,
    input  logic              disp_rsvalid,
    input  logic [TAG_W-1:0]  disp_rstag,
    input  logic [DATA_W-1:0] disp_rtdata,
    input  logic              disp_rtvalid,
    input  logic [TAG_W-1:0]  disp_rttag,
    input  logic [TAG_W-1:0]  disp_rdtag,
    output logic              iq_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              issue_ready,
    output logic              issue_valid,
    output logic [OP_W-1:0]   issue_opcode,
    output logic [DATA_W-1:0] issue_rsdata,
    output logic [DATA_W-1:0] issue_rtdata,
    output logic [TAG_W-1:0]  issue_rdtag
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // Same field order as iq_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] rs_data;
        logic              rs_valid;
        logic [TAG_W-1:0]  rs_tag;
        logic [DATA_W-1:0] rt_data;
        logic              rt_valid;
        logic [TAG_W-1:0]  rt_tag;
        logic [TAG_W-1:0]  rd_tag;
    } entry_t;

    entry_t          entries_q [DEPTH];
    entry_t          entries_d [DEPTH];
    entry_t          woken     [DEPTH];
    entry_t          disp_entry;
    logic [CntW-1:0] count_q, count_d, count_after;
    logic [DEPTH-1:0] ready, grant, shift_mask;
    logic            any_ready, fire, disp_ok;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = entries_q[i].valid & entries_q[i].rs_valid & entries_q[i].rt_valid;
        end
    end

    iq_select #(
        .DEPTH(DEPTH)
    ) u_select (
        .ready    (ready),
        .grant    (grant),
        .any_ready(any_ready)
    );

    always_comb begin
        issue_valid  = any_ready;
        issue_opcode = '0;
        issue_rsdata = '0;
        issue_rtdata = '0;
        issue_rdtag  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_opcode = entries_q[i].opcode;
                issue_rsdata = entries_q[i].rs_data;
                issue_rtdata = entries_q[i].rt_data;
                issue_rdtag  = entries_q[i].rd_tag;
            end
        end
    end

    assign iq_full     = (count_q == CntW'(DEPTH));
    assign fire        = any_ready & issue_ready;
    assign disp_ok     = disp_valid & ~iq_full;
    assign count_after = count_q - CntW'(fire);
    assign count_d     = count_after + CntW'(disp_ok);

    // CDB wakeup on stored entries, applied before compaction.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = entries_q[i];
            if (entries_q[i].valid && cdb_valid) begin
                if (!entries_q[i].rs_valid && entries_q[i].rs_tag == cdb_tag) begin
                    woken[i].rs_data  = cdb_data;
                    woken[i].rs_valid = 1'b1;
                end
                if (!entries_q[i].rt_valid && entries_q[i].rt_tag == cdb_tag) begin
                    woken[i].rt_data  = cdb_data;
                    woken[i].rt_valid = 1'b1;
                end
            end
        end
    end

    // Incoming op, with same-cycle CDB bypass for missing sources.
    always_comb begin
        disp_entry.valid    = 1'b1;
        disp_entry.opcode   = disp_opcode;
        disp_entry.rs_data  = disp_rsdata;
        disp_entry.rs_valid = disp_rsvalid;
        disp_entry.rs_tag   = disp_rstag;
        disp_entry.rt_data  = disp_rtdata;
        disp_entry.rt_valid = disp_rtvalid;
        disp_entry.rt_tag   = disp_rttag;
        disp_entry.rd_tag   = disp_rdtag;
        if (cdb_valid && !disp_rsvalid && disp_rstag == cdb_tag) begin
            disp_entry.rs_data  = cdb_data;
            disp_entry.rs_valid = 1'b1;
        end
        if (cdb_valid && !disp_rtvalid && disp_rttag == cdb_tag) begin
            disp_entry.rt_data  = cdb_data;
            disp_entry.rt_valid = 1'b1;
        end
    end

    // Entries at or above the issued slot pull from the slot above.
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            acc           = acc | (fire & grant[i]);
            shift_mask[i] = acc;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            entries_d[i] = shift_mask[i] ? woken[i+1] : woken[i];
        end
        entries_d[DEPTH-1] = shift_mask[DEPTH-1] ? '0 : woken[DEPTH-1];
        if (disp_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CntW'(i) == count_after) begin
                    entries_d[i] = disp_entry;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: reset, issue latency, wakeup, age order,
// full/bypass and flush, with hand-computed expectations.
module tb_int_issue_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        disp_valid;
    logic [3:0]  disp_opcode;
    logic [31:0] disp_rsdata;
    logic        disp_rsvalid;
    logic [5:0]  disp_rstag;
    logic [31:0] disp_rtdata;
    logic        disp_rtvalid;
    logic [5:0]  disp_rttag;
    logic [5:0]  disp_rdtag;
    logic        iq_full;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_ready;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [31:0] issue_rsdata;
    logic [31:0] issue_rtdata;
    logic [5:0]  issue_rdtag;

    int checks = 0;
    int errors = 0;

    int_issue_queue #(
        .DEPTH (DEPTH),
        .DATA_W(32),
        .TAG_W (6),
        .OP_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_opcode (disp_opcode),
        .disp_rsdata (disp_rsdata),
        .disp_rsvalid(disp_rsvalid),
        .disp_rstag  (disp_rstag),
        .disp_rtdata (disp_rtdata),
        .disp_rtvalid(disp_rtvalid),
        .disp_rttag  (disp_rttag),
        .disp_rdtag  (disp_rdtag),
        .iq_full     (iq_full),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .issue_ready (issue_ready),
        .issue_valid (issue_valid),
        .issue_opcode(issue_opcode),
        .issue_rsdata(issue_rsdata),
        .issue_rtdata(issue_rtdata),
        .issue_rdtag (issue_rdtag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic rsv, input logic [31:0] rsd,
                        input logic [5:0] rst, input logic rtv, input logic [31:0] rtd,
                        input logic [5:0] rtt, input logic [5:0] rd);
        disp_valid   = 1'b1;
        disp_opcode  = op;
        disp_rsvalid = rsv;
        disp_rsdata  = rsd;
        disp_rstag   = rst;
        disp_rtvalid = rtv;
        disp_rtdata  = rtd;
        disp_rttag   = rtt;
        disp_rdtag   = rd;
    endtask

    task automatic nodisp();
        disp_valid = 1'b0;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    task automatic nocdb();
        cdb_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        issue_ready = 1'b0;
        disp_valid = 1'b0;
        disp_opcode = '0;
        disp_rsdata = '0;
        disp_rsvalid = 1'b0;
        disp_rstag = '0;
        disp_rtdata = '0;
        disp_rtvalid = 1'b0;
        disp_rttag = '0;
        disp_rdtag = '0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        cdb_data = '0;

        // 1: reset state, then reset with pending ops
        step();
        step();
        reset = 1'b0;
        check("rst_full", 32'(iq_full), 32'd0);
        check("rst_valid", 32'(issue_valid), 32'd0);
        check("rst_rdtag", 32'(issue_rdtag), 32'd0);
        check("rst_opcode", 32'(issue_opcode), 32'd0);
        check("rst_rs", issue_rsdata, 32'd0);
        check("rst_rt", issue_rtdata, 32'd0);
        disp(4'b0000, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 6'd10);
        step();
        disp(4'b0000, 1'b1, 32'd2, 6'd0, 1'b1, 32'd2, 6'd0, 6'd11);
        step();
        nodisp();
        check("pend_valid", 32'(issue_valid), 32'd1);
        check("pend_rdtag", 32'(issue_rdtag), 32'd10);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst2_full", 32'(iq_full), 32'd0);
        check("rst2_valid", 32'(issue_valid), 32'd0);
        check("rst2_rdtag", 32'(issue_rdtag), 32'd0);

        // 2: ready dispatch issues the next cycle
        issue_ready = 1'b1;
        disp(4'b0000, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 6'd3);
        step();
        nodisp();
        check("rdy_valid", 32'(issue_valid), 32'd1);
        check("rdy_opcode", 32'(issue_opcode), 32'h0);
        check("rdy_rs", issue_rsdata, 32'd5);
        check("rdy_rt", issue_rtdata, 32'd7);
        check("rdy_rdtag", 32'(issue_rdtag), 32'd3);
        step();
        check("rdy_drained", 32'(issue_valid), 32'd0);

        // 3: wakeup from CDB
        disp(4'b0010, 1'b0, 32'd0, 6'd9, 1'b1, 32'd1, 6'd0, 6'd12);
        step();
        nodisp();
        for (int i = 0; i < 3; i++) begin
            check("wk_wait", 32'(issue_valid), 32'd0);
            step();
        end
        cdb(6'd9, 32'h20);
        step();
        nocdb();
        check("wk_valid", 32'(issue_valid), 32'd1);
        check("wk_opcode", 32'(issue_opcode), 32'h2);
        check("wk_rs", issue_rsdata, 32'h20);
        check("wk_rt", issue_rtdata, 32'd1);
        check("wk_rdtag", 32'(issue_rdtag), 32'd12);
        step();
        check("wk_drained", 32'(issue_valid), 32'd0);

        // 4: age order A(waits tag4), B ready, C ready
        disp(4'b0000, 1'b0, 32'd0, 6'd4, 1'b1, 32'd2, 6'd0, 6'd20);
        step();
        disp(4'b0001, 1'b1, 32'd3, 6'd0, 1'b1, 32'd3, 6'd0, 6'd21);
        step();
        check("age_b", 32'(issue_rdtag), 32'd21);
        disp(4'b0100, 1'b1, 32'd4, 6'd0, 1'b1, 32'd4, 6'd0, 6'd22);
        cdb(6'd4, 32'h44);
        step();
        nodisp();
        nocdb();
        check("age_a", 32'(issue_rdtag), 32'd20);
        check("age_a_rs", issue_rsdata, 32'h44);
        step();
        check("age_c", 32'(issue_rdtag), 32'd22);
        check("age_c_op", 32'(issue_opcode), 32'h4);
        step();
        check("age_drained", 32'(issue_valid), 32'd0);

        // 5: fill, drop when full, dispatch-time CDB bypass
        issue_ready = 1'b0;
        disp(4'b0000, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 6'd30);
        step();
        disp(4'b0000, 1'b1, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 6'd31);
        step();
        check("fill3_full", 32'(iq_full), 32'd0);
        disp(4'b0010, 1'b0, 32'd0, 6'd7, 1'b1, 32'd5, 6'd0, 6'd32);
        step();
        disp(4'b0101, 1'b1, 32'h11, 6'd0, 1'b0, 32'd0, 6'd6, 6'd33);
        cdb(6'd6, 32'hAB);
        step();
        nocdb();
        check("full_set", 32'(iq_full), 32'd1);
        disp(4'b0100, 1'b1, 32'd9, 6'd0, 1'b1, 32'd9, 6'd0, 6'd34);
        step();
        check("full_hold", 32'(iq_full), 32'd1);
        check("full_head", 32'(issue_rdtag), 32'd30);
        issue_ready = 1'b1;
        step();
        nodisp();
        check("full_issue_full", 32'(iq_full), 32'd0);
        check("full_issue_next", 32'(issue_rdtag), 32'd31);
        step();
        check("byp_rdtag", 32'(issue_rdtag), 32'd33);
        check("byp_rs", issue_rsdata, 32'h11);
        check("byp_rt", issue_rtdata, 32'hAB);
        check("byp_op", 32'(issue_opcode), 32'h5);
        step();
        check("drop_5th", 32'(issue_valid), 32'd0);

        // 6: flush overrides same-cycle dispatch
        flush = 1'b1;
        step();
        flush = 1'b0;
        issue_ready = 1'b0;
        disp(4'b0000, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 6'd40);
        step();
        disp(4'b0000, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 6'd41);
        step();
        disp(4'b0000, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 6'd42);
        step();
        nodisp();
        check("fl_pre", 32'(issue_rdtag), 32'd40);
        flush = 1'b1;
        disp(4'b0000, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 6'd43);
        step();
        flush = 1'b0;
        nodisp();
        check("fl_valid", 32'(issue_valid), 32'd0);
        check("fl_full", 32'(iq_full), 32'd0);
        check("fl_rdtag", 32'(issue_rdtag), 32'd0);
        step();
        check("fl_still", 32'(issue_valid), 32'd0);
        disp(4'b0001, 1'b1, 32'h55, 6'd0, 1'b1, 32'h66, 6'd0, 6'd44);
        step();
        nodisp();
        check("fl_after_valid", 32'(issue_valid), 32'd1);
        check("fl_after_rdtag", 32'(issue_rdtag), 32'd44);
        check("fl_after_rs", issue_rsdata, 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
